// File: rtl/regfile_hilo_pkg.sv
// Shared widths, constants and write-back bundle layout for the register file
// and the MEM/WB pipeline register.
package regfile_hilo_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned NUM_REGS = 32;

   localparam logic [DATA_W-1:0] ZERO_WORD = DATA_W'(0);
   localparam logic [ADDR_W-1:0] REG_ZERO  = ADDR_W'(0);

   // Write-back bundle field widths, as packed by the MEM/WB register
   localparam int unsigned WB_GPR_W    = 1 + ADDR_W + DATA_W;
   localparam int unsigned WB_HILO_W   = 1 + 2 * DATA_W;
   localparam int unsigned WB_BUNDLE_W = WB_GPR_W + WB_HILO_W;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] waddr;
      logic [DATA_W-1:0] wdata;
      logic              whilo;
      logic [DATA_W-1:0] hi;
      logic [DATA_W-1:0] lo;
   } wb_bundle_t;

endpackage

// File: rtl/regfile_hilo_hilo_reg.sv
// HI/LO register pair, written together; same-cycle forwarding when
// REGFILE_WB_BYPASS_EN is defined.
module hilo_reg
   import regfile_hilo_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wb_whilo,
   input  logic [DATA_W-1:0] wb_hi,
   input  logic [DATA_W-1:0] wb_lo,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);

   logic [DATA_W-1:0] hi_q;
   logic [DATA_W-1:0] lo_q;
   logic              byp;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hi_q <= ZERO_WORD;
         lo_q <= ZERO_WORD;
      end else if (wb_whilo) begin
         hi_q <= wb_hi;
         lo_q <= wb_lo;
      end
   end

`ifdef REGFILE_WB_BYPASS_EN
   // Gated by reset_n so the outputs read zero while in reset
   assign byp = reset_n & wb_whilo;
`else
   assign byp = 1'b0;
`endif

   always_comb begin
      hi_o = hi_q;
      lo_o = lo_q;
      if (byp) begin
         hi_o = wb_hi;
         lo_o = wb_lo;
      end
   end

endmodule

// File: rtl/regfile_hilo.sv
// Write-back architectural state: 32 GPRs (r0 fixed at zero) with two read
// ports, plus HI/LO. Optional forwarding via REGFILE_WB_BYPASS_EN.
module regfile_hilo
   import regfile_hilo_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_waddr,
   input  logic [DATA_W-1:0] wb_wdata,
   input  logic              wb_whilo,
   input  logic [DATA_W-1:0] wb_hi,
   input  logic [DATA_W-1:0] wb_lo,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);

   wb_bundle_t        wb;
   logic [DATA_W-1:0] regs [NUM_REGS];
   logic              byp1;
   logic              byp2;

   assign wb = '{we: wb_we, waddr: wb_waddr, wdata: wb_wdata,
                 whilo: wb_whilo, hi: wb_hi, lo: wb_lo};

   // GPR storage; index 0 is never written so it stays zero
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            regs[i] <= ZERO_WORD;
         end
      end else if (wb.we && (wb.waddr != REG_ZERO)) begin
         regs[wb.waddr] <= wb.wdata;
      end
   end

`ifdef REGFILE_WB_BYPASS_EN
   assign byp1 = reset_n & wb.we & (wb.waddr == raddr1);
   assign byp2 = reset_n & wb.we & (wb.waddr == raddr2);
`else
   assign byp1 = 1'b0;
   assign byp2 = 1'b0;
`endif

   // Read port 1: disable, then r0, then forward, then storage
   always_comb begin
      rdata1 = ZERO_WORD;
      if (re1 && (raddr1 != REG_ZERO)) begin
         rdata1 = byp1 ? wb.wdata : regs[raddr1];
      end
   end

   // Read port 2
   always_comb begin
      rdata2 = ZERO_WORD;
      if (re2 && (raddr2 != REG_ZERO)) begin
         rdata2 = byp2 ? wb.wdata : regs[raddr2];
      end
   end

   hilo_reg u_hilo_reg (
      .clk      (clk),
      .reset_n  (reset_n),
      .wb_whilo (wb.whilo),
      .wb_hi    (wb.hi),
      .wb_lo    (wb.lo),
      .hi_o     (hi_o),
      .lo_o     (lo_o)
   );

endmodule

// File: doc/regfile_hilo.md
Name: regfile_hilo

Overview:
- Architectural state at the write-back end of the 5-stage pipeline.
- Consumes the write-back bundle (GPR write plus HI/LO write) from the MEM/WB pipeline register.
- Provides two GPR read ports and the HI/LO values to the decode and execute stages.
- Holds 32 general-purpose registers (r0 hardwired to zero) and the HI/LO pair used by mult/div and move instructions.

Parameters:
- DATA_W, 32, width of GPRs, HI and LO.
- ADDR_W, 5, register index width.
- NUM_REGS, 32, number of GPRs; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- wb_we  input  1  GPR write enable from the write-back stage.
- wb_waddr  input  ADDR_W  GPR write index.
- wb_wdata  input  DATA_W  GPR write data.
- wb_whilo  input  1  HI/LO write enable.
- wb_hi  input  DATA_W  HI write data.
- wb_lo  input  DATA_W  LO write data.
- re1  input  1  read port 1 enable.
- raddr1  input  ADDR_W  read port 1 index.
- rdata1  output  DATA_W  read port 1 data (combinational).
- re2  input  1  read port 2 enable.
- raddr2  input  ADDR_W  read port 2 index.
- rdata2  output  DATA_W  read port 2 data (combinational).
- hi_o  output  DATA_W  current HI value (combinational).
- lo_o  output  DATA_W  current LO value (combinational).

Behaviour:
- Reset:
  - reset_n low clears every GPR, HI and LO to 0 asynchronously.
  - A write presented during reset is dropped.
  - Reset asserted mid-operation discards all state and takes priority over any write in flight.
  - While in reset, rdata1/rdata2/hi_o/lo_o read 0.
- GPR write:
  - On posedge clk with reset_n high, wb_we=1 and wb_waddr!=0: regs[wb_waddr] <= wb_wdata.
  - Writes to index 0 are ignored; r0 always reads 0.
- HI/LO write:
  - On posedge clk with wb_whilo=1: HI <= wb_hi and LO <= wb_lo, always as a pair.
  - wb_whilo is independent of wb_we; both may be asserted in the same cycle and both take effect.
- Read port n (n=1,2), priority order:
  1. re_n=0 -> rdata_n = 0.
  2. raddr_n = 0 -> rdata_n = 0.
  3. Bypass condition (see Optional Feature) -> rdata_n = wb_wdata.
  4. Otherwise rdata_n = regs[raddr_n].
- Both read ports are independent. The same address on both ports returns identical data.
- Read latency is 0 cycles (combinational). Write latency is 1 cycle: written data appears in storage after the clock edge.
- HI/LO outputs:
  - hi_o/lo_o show stored HI/LO.
  - With the bypass feature, wb_whilo=1 makes hi_o=wb_hi and lo_o=wb_lo in the same cycle.
- X-handling: when wb_we=0 or wb_whilo=0, the corresponding data inputs are don't-care and must not affect state.
- No stall input: the upstream stage register already holds its bundle during stalls. A repeated identical write is idempotent.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined:
  - Same-cycle write-to-read forwarding on both ports: re_n=1, wb_we=1, wb_waddr==raddr_n, raddr_n!=0 -> rdata_n = wb_wdata.
  - HI/LO forwarded likewise when wb_whilo=1.
  - Removes the ID-after-WB read hazard.
- Undefined:
  - Reads return stored values only; the write becomes visible the cycle after the edge.
  - Decode-stage interlock must cover the hazard.

Decomposition:
- Shared package/header:
  - DATA_W, ADDR_W, NUM_REGS.
  - ZERO_WORD (32'h0) and REG_ZERO index (5'd0) constants.
  - Write-back bundle field widths, shared with the MEM/WB pipeline register.
- One sub-module: hilo_reg (HI/LO pair with its write and optional bypass). The GPR array and read muxes stay in the top.

Test Plan:
- Reset then read: reset_n=0 for 2 cycles, release; re1=re2=1 with raddr1=5, raddr2=31 -> rdata1=rdata2=0, hi_o=lo_o=0.
- Basic write/read: wb_we=1, waddr=3, wdata=32'hDEADBEEF for one cycle; next cycle raddr1=3 -> rdata1=32'hDEADBEEF; with re1=0 -> 0.
- r0 protection: write waddr=0, wdata=32'hFFFFFFFF -> raddr1=0 reads 0 the next cycle and afterwards.
- Bypass: same cycle wb_we=1, waddr=7, wdata=32'h12345678, raddr2=7:
  - With REGFILE_WB_BYPASS_EN -> rdata2=32'h12345678 that cycle.
  - Without -> old value (0) that cycle, 32'h12345678 the next.
- HI/LO with simultaneous GPR write: wb_whilo=1, hi=32'h1, lo=32'h2, plus wb_we=1, waddr=9, wdata=32'hA -> next cycle hi_o=1, lo_o=2, raddr1=9 reads 32'hA.
- Mid-operation reset: write 32'h55 to r4; assert reset_n low asynchronously mid-cycle while wb_we=1, waddr=4, wdata=32'h77 -> r4 reads 0 after release; no write lands.
